sync_fifo_16x64: RTL and testbench
==================================

# sync_fifo_16x64

Single-clock first-word-fall-through FIFO, 16 entries of 64 bits, with occupancy counters and error flags. It sits between a producer and a consumer in the same clock domain and is used as the standard buffering element in datapath glue. Storage is a flop/RAM array, and read data is combinational from the read pointer. The block reports occupancy (used/free), empty/full status and one-cycle underflow/overflow error pulses.

## Interface
- DEPTH, 16, number of entries; must be a power of two.
- WIDTH, 64, data width in bits.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronous to clk.
- wen  input  1  write request.
- ren  input  1  read request (pop).
- clear  input  1  synchronous flush.
- wdata  input  WIDTH  write data.
- rdata  output  WIDTH  head-of-queue data.
- empty  output  1  used_slots == 0.
- full  output  1  used_slots == DEPTH.
- used_slots  output  log2(DEPTH)+1 (5)  current occupancy, 0..16.
- free_slots  output  log2(DEPTH)+1 (5)  DEPTH − used_slots.
- underflow  output  1  registered error pulse.
- overflow  output  1  registered error pulse.

## Operation
- State:
  - wptr and rptr, each log2(DEPTH) bits (4), wrapping 15→0.
  - used count, 5 bits.
  - Storage array of DEPTH×WIDTH.
  - underflow/overflow registers.
- Write accept: wr_ok = wen & ~full.
  - On accept, wdata is stored at mem[wptr] and wptr increments.
  - A write while full is dropped and sets overflow for one cycle.
- Read accept: rd_ok = ren & ~empty.
  - On accept, rptr increments.
  - A read while empty is ignored and sets underflow for one cycle.
- Occupancy: used_next = used + wr_ok − rd_ok.
- Status outputs:
  - empty and full are decoded combinationally from used.
  - free_slots = DEPTH − used.
- Read data: rdata = mem[rptr] (combinational). Masking when empty is governed by the Configuration macro.
- Simultaneous wen & ren:
  - Not empty and not full: both accepted, used unchanged.
  - Full: the read is accepted and the write is rejected (acceptance uses the pre-edge full), overflow=1, used becomes 15.
  - Empty: the write is accepted and the read is rejected, underflow=1, used becomes 1.
- clear (synchronous) has priority over wen/ren in the same cycle:
  - wptr, rptr and used are set to 0.
  - underflow and overflow are set to 0.
  - Storage contents are not altered.
- Reset (rst_n=0), asynchronous:
  - Pointers and used are set to 0, so empty=1, full=0, used_slots=0, free_slots=16.
  - underflow=0, overflow=0.
  - Reset asserted mid-operation discards all queued data immediately.
  - Storage is not reset. rdata after reset is 0 when the Configuration macro is defined and undefined otherwise.

## Timing
- All state updates on the rising clk edge.
- Write-to-read latency: data written at edge N is valid on rdata (if it is the head) after edge N; a read in cycle N+1 returns it.
- The pop takes effect at the edge. rdata shows the next entry after that edge.
- empty, full, used_slots and free_slots reflect the post-edge state. There is no look-ahead.
- underflow/overflow are high for exactly the one cycle following the offending request edge, and low otherwise.
- There are no combinational paths from wen or ren to any output.

## Configuration
- FIFO_RDATA_MASK_EN defined: rdata is forced to all-zero whenever empty=1; otherwise rdata = mem[rptr]. One AND gate per bit, gated by ~empty.
- FIFO_RDATA_MASK_EN undefined: rdata = mem[rptr] unconditionally. When empty it shows stale or undefined data.

## Test plan
- Reset then idle:
  - Required: empty=1, full=0, used=0, free=16, flags 0.
  - With FIFO_RDATA_MASK_EN: rdata=0.
- Write 0x1..0x10 on 16 consecutive cycles:
  - After each edge, used=1..16.
  - After the last edge, full=1 and free=0.
  - rdata=0x1 from the first edge onward.
- With the FIFO full, wen=1 with wdata=0xDEAD:
  - Next cycle: overflow=1 for one cycle, used stays 16.
  - Draining 16 reads returns 0x1..0x10 in order, never 0xDEAD.
- Empty FIFO, ren=1: underflow=1 for one cycle, used=0, rptr unchanged.
  - Then simultaneous wen=1/ren=1 with wdata=0x55: underflow pulses again, used=1, rdata=0x55.
- Fill to 5, then hold wen=ren=1 for 40 cycles with an incrementing wdata:
  - used stays 5 throughout.
  - Output order is preserved across pointer wrap.
- Fill to 9, then assert clear together with wen=1:
  - Next cycle: used=0, empty=1, flags 0.
  - Assert rst_n low mid-burst: outputs return to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_16x64.sv
// First-word-fall-through FIFO, DEPTH x WIDTH, with occupancy counts and one-cycle error pulses.
// Latency: a write is visible on rdata after one edge. Full drops writes (overflow); empty ignores reads (underflow).
// Optional: define FIFO_RDATA_MASK_EN to force rdata to zero while empty.
module sync_fifo_16x64 #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wen,
  input  logic                       ren,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     used_slots,
  output logic [$clog2(DEPTH):0]     free_slots,
  output logic                       underflow,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    used;
  logic [CW-1:0]    used_next;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (used == '0);
  assign full  = (used == CW'(DEPTH));

  // Acceptance is decided on the pre-edge status, so a read frees no slot for a same-cycle write.
  assign wr_ok = wen & ~full;
  assign rd_ok = ren & ~empty;

  assign used_next = used + CW'(wr_ok) - CW'(rd_ok);

  // Storage carries no reset and is left untouched by clear.
  always_ff @(posedge clk) begin
    if (wr_ok && !clear) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      used      <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else if (clear) begin
      wptr      <= '0;
      rptr      <= '0;
      used      <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
      used      <= used_next;
      underflow <= ren & empty;
      overflow  <= wen & full;
    end
  end

  assign used_slots = used;
  assign free_slots = CW'(DEPTH) - used;

`ifdef FIFO_RDATA_MASK_EN
  assign rdata = mem[rptr] & {WIDTH{~empty}};
`else
  assign rdata = mem[rptr];
`endif

endmodule

// File: tb/tb_sync_fifo_16x64.sv
// Scoreboard bench for sync_fifo_16x64: a queue model predicts data order, occupancy and error pulses.
module tb_sync_fifo_16x64;

  logic        clk;
  logic        rst_n;
  logic        wen;
  logic        ren;
  logic        clear;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        empty;
  logic        full;
  logic [4:0]  used_slots;
  logic [4:0]  free_slots;
  logic        underflow;
  logic        overflow;

  int checks;
  int errors;
  logic [63:0] sb_q[$];
  logic        exp_ovf;
  logic        exp_udf;
  logic [63:0] data_ctr;

  sync_fifo_16x64 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen        (wen),
    .ren        (ren),
    .clear      (clear),
    .wdata      (wdata),
    .rdata      (rdata),
    .empty      (empty),
    .full       (full),
    .used_slots (used_slots),
    .free_slots (free_slots),
    .underflow  (underflow),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_used"},  64'(used_slots), 64'(sb_q.size()));
    check({tag, "_free"},  64'(free_slots), 64'(16 - sb_q.size()));
    check({tag, "_empty"}, 64'(empty),      64'(sb_q.size() == 0));
    check({tag, "_full"},  64'(full),       64'(sb_q.size() == 16));
    check({tag, "_ovf"},   64'(overflow),   64'(exp_ovf));
    check({tag, "_udf"},   64'(underflow),  64'(exp_udf));
  endtask

  // Called #1 after a rising edge; drives one cycle of stimulus and checks the post-edge state.
  task automatic cycle(input logic w, input logic r, input logic c, input logic [63:0] d);
    logic was_full;
    logic was_empty;
    was_full  = (sb_q.size() == 16);
    was_empty = (sb_q.size() == 0);
    wen   = w;
    ren   = r;
    clear = c;
    wdata = d;
    if (!was_empty) check("head", rdata, sb_q[0]);
    if (c) begin
      sb_q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      if (r && !was_empty) void'(sb_q.pop_front());
      if (w && !was_full) sb_q.push_back(d);
      exp_ovf = w & was_full;
      exp_udf = r & was_empty;
    end
    @(posedge clk);
    #1;
    wen   = 1'b0;
    ren   = 1'b0;
    clear = 1'b0;
    check_status("cyc");
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    data_ctr = 64'h100;
    rst_n = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    clear = 1'b0;
    wdata = '0;

    #12;
    check_status("reset");
`ifdef FIFO_RDATA_MASK_EN
    check("reset_rdata", rdata, 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0, 1'b0, 64'h0);

    // Fill with 1..16, then push into a full FIFO.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 1'b0, 64'(i));
    check("full_rdata", rdata, 64'h1);
    cycle(1'b1, 1'b0, 1'b0, 64'hDEAD);
    cycle(1'b0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 64'h0);

    // Underflow alone, then with a simultaneous write into the empty FIFO.
    cycle(1'b0, 1'b1, 1'b0, 64'h0);
    cycle(1'b1, 1'b1, 1'b0, 64'h55);
    check("wr_on_empty_rdata", rdata, 64'h55);
    cycle(1'b0, 1'b1, 1'b0, 64'h0);

    // Steady-state streaming at occupancy 5 across pointer wrap.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, data_ctr);
      data_ctr++;
    end
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b1, 1'b0, data_ctr);
      data_ctr++;
    end

    // Grow to 9, then clear wins over a concurrent write.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, data_ctr);
      data_ctr++;
    end
    check("pre_clear_used", 64'(used_slots), 64'd9);
    cycle(1'b1, 1'b0, 1'b1, 64'hBEEF);
    cycle(1'b0, 1'b0, 1'b0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'hA1);
    cycle(1'b1, 1'b1, 1'b0, 64'hA2);

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, data_ctr);
      data_ctr++;
    end
    wen   = 1'b1;
    wdata = 64'hF00D;
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    check_status("async_rst");
`ifdef FIFO_RDATA_MASK_EN
    check("async_rst_rdata", rdata, 64'h0);
`endif
    wen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 1'b0, 64'hC1);
    cycle(1'b1, 1'b0, 1'b0, 64'hC2);
    cycle(1'b0, 1'b1, 1'b0, 64'h0);
    cycle(1'b0, 1'b1, 1'b0, 64'h0);
    cycle(1'b0, 1'b0, 1'b0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
